// File: rtl/writeback_stage.sv
// MEM/WB stage: selects the write-back source, waits on variable-latency loads,
// and drives one registered register-file write port (also the WB forwarding source).
module writeback_stage #(
  parameter int LOAD_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wren,
  input  logic [4:0]       in_waddr,
  input  logic [1:0]       in_wb_sel,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_link_pc,
  input  logic [2:0]       in_load_type,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic [4:0]       waddr,
  output logic [31:0]      wdata,
  output logic             wren,
  output logic             align_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retire_count
);

  // state     | meaning
  // IDLE      | ready to accept; non-loads and misaligned loads retire here
  // WAIT_LOAD | aligned load accepted, waiting for mem_rvalid or timeout
  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  localparam int            TW  = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(LOAD_TIMEOUT);

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [4:0]    pend_waddr_q;
  logic          pend_wren_q;
  logic [2:0]    pend_type_q;
  logic [1:0]    pend_off_q;

  logic          accept, is_load, aligned, tmo_hit, latch;
  logic [TW-1:0] cnt_inc;
  logic [4:0]    waddr_d;
  logic [31:0]   wdata_d;
  logic          wren_d, align_d, tmo_set, retire_inc;

  // Big-endian lanes: offset 0 is the most significant byte/halfword.
  function automatic logic [31:0] extract(input logic [2:0] lt, input logic [1:0] off,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = off[1] ? rd[15:0] : rd[31:16];
    case (lt)
      3'd1:    extract = {{16{h[15]}}, h};
      3'd2:    extract = {16'h0, h};
      3'd3:    extract = {{24{b[7]}}, b};
      3'd4:    extract = {24'h0, b};
      default: extract = rd;
    endcase
  endfunction

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_load  = (in_wb_sel == 2'd1);
  assign cnt_inc  = tmo_cnt_q + TW'(1);
  assign tmo_hit  = (cnt_inc == TMO);

  always_comb begin
    case (in_load_type)
      3'd1, 3'd2: aligned = !in_alu_result[0];
      3'd3, 3'd4: aligned = 1'b1;
      default:    aligned = (in_alu_result[1:0] == 2'b00);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && is_load && aligned) state_d = WAIT_LOAD;
      WAIT_LOAD: if (mem_rvalid || tmo_hit)        state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    wren_d     = 1'b0;
    waddr_d    = waddr;
    wdata_d    = wdata;
    align_d    = 1'b0;
    tmo_set    = 1'b0;
    retire_inc = 1'b0;
    latch      = 1'b0;
    tmo_cnt_d  = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_load) begin
            wdata_d    = (in_wb_sel == 2'd2) ? in_link_pc : in_alu_result;
            waddr_d    = in_waddr;
            wren_d     = in_wren && (in_waddr != 5'd0);
            retire_inc = 1'b1;
          end else if (!aligned) begin
            align_d    = 1'b1;
            retire_inc = 1'b1;
          end else begin
            latch     = 1'b1;
            tmo_cnt_d = '0;
          end
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the timeout edge wins over the timeout.
        if (mem_rvalid) begin
          wdata_d    = extract(pend_type_q, pend_off_q, mem_rdata);
          waddr_d    = pend_waddr_q;
          wren_d     = pend_wren_q && (pend_waddr_q != 5'd0);
          retire_inc = 1'b1;
        end else if (tmo_hit) begin
          tmo_set    = 1'b1;
          retire_inc = 1'b1;
          tmo_cnt_d  = '0;
        end else begin
          tmo_cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr        <= '0;
      wdata        <= '0;
      wren         <= 1'b0;
      align_err    <= 1'b0;
      timeout_err  <= 1'b0;
      retire_count <= '0;
      tmo_cnt_q    <= '0;
      pend_waddr_q <= '0;
      pend_wren_q  <= 1'b0;
      pend_type_q  <= '0;
      pend_off_q   <= '0;
    end else begin
      waddr       <= waddr_d;
      wdata       <= wdata_d;
      wren        <= wren_d;
      align_err   <= align_d;
      timeout_err <= timeout_err | tmo_set;
      tmo_cnt_q   <= tmo_cnt_d;
      if (retire_inc) retire_count <= retire_count + CNT_W'(1);
      if (latch) begin
        pend_waddr_q <= in_waddr;
        pend_wren_q  <= in_wren;
        pend_type_q  <= in_load_type;
        pend_off_q   <= in_alu_result[1:0];
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_wren;
  logic [4:0]  in_waddr;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result, in_link_pc;
  logic [2:0]  in_load_type;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wren, align_err, timeout_err;
  logic [31:0] retire_count;

  int checks = 0;
  int failures = 0;

  writeback_stage #(.LOAD_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_wren(in_wren), .in_waddr(in_waddr), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_link_pc(in_link_pc),
    .in_load_type(in_load_type), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .waddr(waddr), .wdata(wdata), .wren(wren), .align_err(align_err),
    .timeout_err(timeout_err), .retire_count(retire_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [1:0] sel, input logic [4:0] wa, input logic we,
                        input logic [31:0] alu, input logic [31:0] link);
    in_valid = 1'b1; in_wb_sel = sel; in_waddr = wa; in_wren = we;
    in_alu_result = alu; in_link_pc = link;
    tick();
    in_valid = 1'b0;
  endtask

  // Accept a load, then raise mem_rvalid on the lat-th edge after acceptance.
  task automatic run_load(input logic [2:0] lt, input logic [31:0] addr, input logic [4:0] wa,
                          input logic [31:0] rd, input int lat, input string tag);
    in_valid = 1'b1; in_wb_sel = 2'd1; in_load_type = lt; in_waddr = wa; in_wren = 1'b1;
    in_alu_result = addr;
    tick();
    in_valid = 1'b0;
    check({tag, "_accept_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_accept_wren"}, 32'(wren), 32'd0);
    mem_rdata = rd;
    for (int i = 1; i <= lat; i++) begin
      mem_rvalid = (i == lat);
      tick();
      if (i < lat) check({tag, "_wait_ready"}, 32'(in_ready), 32'd0);
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_wren = 1'b0; in_waddr = '0; in_wb_sel = '0;
    in_alu_result = '0; in_link_pc = '0; in_load_type = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_retire", retire_count, 32'd0);
    check("rst_errs", {30'd0, align_err, timeout_err}, 32'd0);
    rst_n = 1'b1;

    // back-to-back ALU ops
    in_valid = 1'b1; in_wb_sel = 2'd0; in_wren = 1'b1; in_waddr = 5'd5; in_alu_result = 32'h1234;
    tick();
    check("alu1_wren", 32'(wren), 32'd1);
    check("alu1_waddr", 32'(waddr), 32'd5);
    check("alu1_wdata", wdata, 32'h1234);
    check("alu1_ready", 32'(in_ready), 32'd1);
    in_waddr = 5'd6; in_alu_result = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    check("alu2_wren", 32'(wren), 32'd1);
    check("alu2_waddr", 32'(waddr), 32'd6);
    check("alu2_wdata", wdata, 32'hDEADBEEF);
    check("alu2_retire", retire_count, 32'd2);
    tick();
    check("idle_wren", 32'(wren), 32'd0);
    check("idle_wdata_hold", wdata, 32'hDEADBEEF);

    // lb / lbu at offset 2, data after 3 cycles
    run_load(3'd3, 32'h1002, 5'd7, 32'h0011F233, 3, "lb");
    check("lb_wren", 32'(wren), 32'd1);
    check("lb_waddr", 32'(waddr), 32'd7);
    check("lb_wdata", wdata, 32'hFFFFFFF2);
    check("lb_retire", retire_count, 32'd3);
    check("lb_ready", 32'(in_ready), 32'd1);
    tick();
    check("lb_wren_pulse", 32'(wren), 32'd0);
    run_load(3'd4, 32'h1002, 5'd7, 32'h0011F233, 3, "lbu");
    check("lbu_wdata", wdata, 32'h000000F2);
    check("lbu_retire", retire_count, 32'd4);

    // misaligned lh, then lhu / lw / lh variants
    in_valid = 1'b1; in_wb_sel = 2'd1; in_load_type = 3'd1; in_waddr = 5'd8; in_alu_result = 32'h2001;
    tick();
    in_valid = 1'b0;
    check("lh_mis_align", 32'(align_err), 32'd1);
    check("lh_mis_wren", 32'(wren), 32'd0);
    check("lh_mis_ready", 32'(in_ready), 32'd1);
    check("lh_mis_retire", retire_count, 32'd5);
    tick();
    check("lh_mis_pulse", 32'(align_err), 32'd0);
    run_load(3'd2, 32'h2002, 5'd9, 32'hAAAA8001, 1, "lhu");
    check("lhu_wdata", wdata, 32'h00008001);
    check("lhu_waddr", 32'(waddr), 32'd9);
    run_load(3'd0, 32'h3000, 5'd10, 32'hCAFEF00D, 2, "lw");
    check("lw_wdata", wdata, 32'hCAFEF00D);
    run_load(3'd1, 32'h3000, 5'd10, 32'h9ABC1234, 1, "lh");
    check("lh_wdata", wdata, 32'hFFFF9ABC);
    check("lh_retire", retire_count, 32'd8);

    // jal, r0 write, reserved sel, no-write instruction
    alu_op(2'd2, 5'd31, 1'b1, 32'h55, 32'h00400008);
    check("jal_wdata", wdata, 32'h00400008);
    check("jal_waddr", 32'(waddr), 32'd31);
    check("jal_wren", 32'(wren), 32'd1);
    alu_op(2'd0, 5'd0, 1'b1, 32'h77, 32'h0);
    check("r0_wren", 32'(wren), 32'd0);
    check("r0_retire", retire_count, 32'd10);
    alu_op(2'd3, 5'd11, 1'b1, 32'h1111, 32'h2222);
    check("sel3_wdata", wdata, 32'h1111);
    check("sel3_wren", 32'(wren), 32'd1);
    alu_op(2'd0, 5'd12, 1'b0, 32'h3333, 32'h0);
    check("nowren_wren", 32'(wren), 32'd0);
    check("nowren_retire", retire_count, 32'd12);

    // load timeout (LOAD_TIMEOUT=4)
    run_load(3'd0, 32'h4000, 5'd13, 32'h0, 0, "tmo");
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("tmo_wait_ready", 32'(in_ready), 32'd0);
      check("tmo_wait_err", 32'(timeout_err), 32'd0);
    end
    tick();
    check("tmo_ready", 32'(in_ready), 32'd1);
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_wren", 32'(wren), 32'd0);
    check("tmo_retire", retire_count, 32'd13);
    alu_op(2'd0, 5'd14, 1'b1, 32'hABCD, 32'h0);
    check("post_tmo_wdata", wdata, 32'hABCD);
    check("post_tmo_wren", 32'(wren), 32'd1);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    check("post_tmo_retire", retire_count, 32'd14);

    // reset two cycles into WAIT_LOAD
    run_load(3'd0, 32'h5000, 5'd15, 32'h0, 0, "rstld");
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_wdata", wdata, 32'd0);
    check("mid_rst_retire", retire_count, 32'd0);
    check("mid_rst_tmo", 32'(timeout_err), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h87654321;
    tick();
    mem_rvalid = 1'b0;
    check("late_rvalid_wren", 32'(wren), 32'd0);
    check("late_rvalid_retire", retire_count, 32'd0);

    // data on the same edge the timeout would fire
    run_load(3'd0, 32'h6000, 5'd16, 32'h13572468, 4, "edge");
    check("edge_wren", 32'(wren), 32'd1);
    check("edge_wdata", wdata, 32'h13572468);
    check("edge_tmo", 32'(timeout_err), 32'd0);
    check("edge_retire", retire_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline stage of the MIPS core, sitting directly upstream of the register file.
- Captures retiring instructions and selects the write-back source (ALU result, load data, or link PC).
- Waits on a variable-latency data-memory read for loads, and drives one registered write port (waddr/wdata/wren) into the register file.
- The same registered outputs are the WB-stage forwarding source for the execute stage.

Parameters:
- LOAD_TIMEOUT, 64, maximum cycles spent in WAIT_LOAD before the load is abandoned; must be at least 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept; combinational, equals (state==IDLE)
- in_wren  input  1  instruction writes a register
- in_waddr  input  5  destination register
- in_wb_sel  input  2  0=ALU, 1=load, 2=link, 3=reserved (treated as ALU)
- in_alu_result  input  32  ALU result; also the load effective address
- in_link_pc  input  32  PC+8 for jal/jalr
- in_load_type  input  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu, 5-7 treated as lw
- mem_rvalid  input  1  data-memory read data valid
- mem_rdata  input  32  data-memory read word, big-endian byte lanes
- waddr  output  5  register file write address
- wdata  output  32  register file write data
- wren  output  1  register file write enable, one-cycle pulse
- align_err  output  1  one-cycle pulse, misaligned load dropped
- timeout_err  output  1  sticky flag, a load timed out; cleared only by reset
- retire_count  output  CNT_W  number of retired instructions

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: waddr=0, wdata=0, wren=0, align_err=0, timeout_err=0, retire_count=0, state=IDLE, timeout counter=0. in_ready=1 while rst_n is low and immediately after.
- Reset mid-WAIT_LOAD discards the pending load; no write is issued.
- State machine has two states, IDLE and WAIT_LOAD.
- An instruction is accepted at a rising edge when in_valid and in_ready are both high.
- IDLE, non-load accepted (in_wb_sel != 1):
  - At the same edge: wdata = ALU result (or link PC if in_wb_sel=2), waddr = in_waddr, wren = in_wren && (in_waddr != 0).
  - retire_count increments. State stays IDLE, so back-to-back acceptance every cycle is allowed.
  - Latency: 1 cycle.
- IDLE, load accepted:
  - Alignment check uses in_alu_result[1:0]. lw requires 00; lh/lhu require bit0=0; lb/lbu are always aligned.
  - Misaligned: align_err pulses for one cycle, wren=0, retire_count increments, stay IDLE.
  - Aligned: latch waddr, wren-intent, load type and byte offset; clear the timeout counter; go to WAIT_LOAD. wren=0 that cycle.
- WAIT_LOAD:
  - mem_rvalid is ignored in the acceptance cycle and sampled from the next edge on.
  - On an edge with mem_rvalid=1:
    - Extract data from mem_rdata. Byte offset 0 selects bits [31:24] (or halfword [31:16]).
    - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
    - wren pulses (suppressed if waddr=0), retire_count increments, go to IDLE.
  - Otherwise the counter increments. When it reaches LOAD_TIMEOUT: timeout_err is set, no write is issued, retire_count increments, go to IDLE.
  - mem_rvalid arriving on the same edge the counter reaches LOAD_TIMEOUT is treated as valid data and no timeout is flagged.
- wren is deasserted on every edge that does not write; waddr and wdata hold their last value.
- Register r0 is never written (wren=0), even though the instruction still retires.
- retire_count wraps modulo 2^CNT_W.
- in_valid while in_ready=0 is not accepted; upstream must hold the instruction.

Test Plan:
- ALU ops to r5 (0x1234) and r6 (0xDEADBEEF) on consecutive cycles -> wren high 2 cycles, waddr 5 then 6, wdata matches, retire_count=2, in_ready stays 1.
- lb at addr offset 2, mem_rdata=0x0011F233, mem_rvalid 3 cycles later -> in_ready=0 for 3 cycles, then wdata=0xFFFFFFF2, wren 1 cycle; the same case with lbu -> 0x000000F2.
- lh at offset 1 -> align_err pulse, no wren, in_ready stays 1, retire_count+1; lhu at offset 2 with rdata 0xAAAA8001 -> wdata=0x00008001.
- jal (wb_sel=2, waddr=31, link_pc=0x00400008) -> wdata=0x00400008; ALU op to r0 -> wren=0, retire_count+1.
- Load with mem_rvalid never asserted, LOAD_TIMEOUT=4 -> in_ready low 4 cycles, timeout_err set and sticky, no write; the next ALU instruction proceeds normally.
- rst_n pulled low 2 cycles into WAIT_LOAD -> all outputs 0 and in_ready=1 immediately; a later mem_rvalid causes no write.
